jtexterm_pal_sched: RTL and testbench
=====================================

JTEXTERM_PAL_SCHED -- requirements
Module: jtexterm_pal_sched

Interface
REQ-001 SHALL have parameter PXL_MIN, default 4, meaning the minimum clk cycles between pxl_cen pulses the block supports.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-high reset; clk  in  1  single clock for all logic.
REQ-003 SHALL have ports: pxl_cen  in  1  pixel clock enable; LHBL  in  1  horizontal blank, active low; LVBL  in  1  vertical blank, active low; col_addr  in  9  palette index of the current pixel.
REQ-004 SHALL have ports: cpu_addr  in  10  CPU palette byte address; cpu_dout  in  8  CPU write data; cpu_rnw  in  1  1 = read; pal_cs  in  1  CPU request, held until cpu_ok; cpu_din  out  8  CPU read data; cpu_ok  out  1  one-cycle access-complete pulse.
REQ-005 SHALL have ports: ram_addr  out  10  registered single-port RAM address; ram_din  out  8  RAM write data; ram_we  out  1  RAM write strobe; ram_dout  in  8  RAM read data, valid one clk after ram_addr changes.
REQ-006 SHALL have ports: red, green, blue  out  5 each  registered colour outputs.

Function
REQ-007 SHALL share one 1024x8 single-port palette RAM between video fetches and CPU accesses, with video having absolute priority.
REQ-008 SHALL, on the clk edge with pxl_cen=1 (E0), drive ram_addr={1'b1,col_addr} (high byte) and latch blank=~LHBL|~LVBL.
REQ-009 SHALL, on E1 (next edge), drive ram_addr={1'b0,col_addr} (low byte) with the same col_addr latched at E0.
REQ-010 SHALL capture ram_dout as hi at E2 and as lo at E3.
REQ-011 SHALL, on the next pxl_cen edge, load {red,green,blue}={hi[6:0],lo}[14:0] if the latched blank was 0, else all zero; hi[7] is ignored; pixel-to-colour latency is exactly one pxl_cen period.
REQ-012 SHALL use FSM states IDLE, VHI, VLO, CPU_RD, CPU_DONE: pxl_cen -> VHI from any state; VHI -> VLO; VLO -> IDLE; IDLE with pending request -> CPU_RD (read) or CPU_DONE (write); CPU_RD -> CPU_DONE; CPU_DONE -> IDLE.
REQ-013 SHALL issue a CPU access only on an edge that is neither E0 nor E1, i.e. earliest at E2.
REQ-014 SHALL, for a write, drive ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=1 for exactly one clk, then pulse cpu_ok on the following edge.
REQ-015 SHALL, for a read, drive ram_addr=cpu_addr for one clk, capture ram_dout into cpu_din one edge later, and pulse cpu_ok on that same edge; cpu_din holds until the next read completes.
REQ-016 SHALL treat pal_cs as a new request only after it has been low since the last cpu_ok, so a held pal_cs yields one access.
REQ-017 SHALL, when pxl_cen occurs in CPU_RD, still capture the CPU read data and pulse cpu_ok on that edge while entering VHI; an issued access is never aborted.
REQ-018 SHALL, when pxl_cen and a new request coincide, serve video first and defer the CPU to E2.
REQ-019 SHALL keep ram_we=0 at all times except the single CPU write cycle.
REQ-020 SHALL guarantee at most PXL_MIN+2 clk from request to cpu_ok when pxl_cen spacing is PXL_MIN.

Reset
REQ-021 SHALL, while rst=1, hold FSM in IDLE and red, green, blue, cpu_din, cpu_ok, ram_we, ram_addr, ram_din, hi, lo at zero, with any pending request discarded.
REQ-022 SHALL, after rst release, output zero colour until the first complete pixel fetch.

Structure
REQ-023 SHALL place FSM state encodings and the colour bit-field offsets (14:10, 9:5, 4:0) in a shared package jtexterm_pkg.
REQ-024 SHALL instantiate the RAM outside this block; one sub-module, jtexterm_pal_cpuif (request-edge detect and cpu_ok/cpu_din logic), is natural.

Verification
REQ-025 Preload RAM[0x205]=0x7C, RAM[0x005]=0x1F; col_addr=0x005, LHBL=LVBL=1, pxl_cen every 4 clk -> next pxl_cen gives red=31, green=0, blue=31.
REQ-026 Same pixel with LHBL=0 at E0 -> red=green=blue=0 on next pxl_cen.
REQ-027 CPU write 0x3A to 0x10F asserted on E0 -> ram_we high only at E2 with ram_addr=0x10F; cpu_ok at E3; read-back returns cpu_din=0x3A.
REQ-028 CPU read issued at E2 with pxl_cen spacing 4 -> cpu_ok and valid cpu_din coincide with next E0; video fetch unaffected.
REQ-029 pal_cs held high 20 clk -> exactly one cpu_ok pulse.
REQ-030 rst asserted during CPU_RD -> cpu_ok never pulses, outputs zero immediately, FSM IDLE after release.

Source files
------------

// File: rtl/jtexterm_pkg.sv
// Shared definitions for the palette scheduler: FSM encoding and the
// RGB555 bit-field layout of a palette entry {hi[6:0], lo}.
package jtexterm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VHI      = 3'd1,
        VLO      = 3'd2,
        CPU_RD   = 3'd3,
        CPU_DONE = 3'd4
    } pal_state_e;

    localparam int RED_HI = 14;
    localparam int RED_LO = 10;
    localparam int GRN_HI = 9;
    localparam int GRN_LO = 5;
    localparam int BLU_HI = 4;
    localparam int BLU_LO = 0;

endpackage

// File: rtl/jtexterm_pal_cpuif.sv
// CPU side of the palette scheduler: request edge qualification and the
// cpu_ok / cpu_din completion pipeline, independent of the video FSM.
module jtexterm_pal_cpuif (
    input  logic       rst,
    input  logic       clk,
    input  logic       i_pal_cs,
    input  logic       i_issue_rd,
    input  logic       i_issue_wr,
    input  logic [7:0] i_ram_dout,
    output logic       o_pend,
    output logic       o_cpu_ok,
    output logic [7:0] o_cpu_din
);

    logic r_armed;
    logic r_busy;
    logic r_wr_p;
    logic r_rd_p;
    logic r_rd_p2;

    // A held pal_cs must drop for at least one edge after cpu_ok before it re-arms.
    assign o_pend = i_pal_cs & r_armed & ~r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed   <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_p    <= 1'b0;
            r_rd_p    <= 1'b0;
            r_rd_p2   <= 1'b0;
            o_cpu_ok  <= 1'b0;
            o_cpu_din <= 8'd0;
        end else begin
            r_wr_p   <= i_issue_wr;
            r_rd_p   <= i_issue_rd;
            r_rd_p2  <= r_rd_p;
            o_cpu_ok <= r_wr_p | r_rd_p2;
            if (r_rd_p2)
                o_cpu_din <= i_ram_dout;
            if (i_issue_rd | i_issue_wr) begin
                r_busy  <= 1'b1;
                r_armed <= 1'b0;
            end else if (r_wr_p | r_rd_p2) begin
                r_busy  <= 1'b0;
            end else if (!i_pal_cs && !r_busy) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtexterm_pal_sched.sv
// Palette RAM arbiter: two-byte video fetch per pixel with absolute priority,
// CPU accesses slotted into the remaining cycles of each pixel period.
module jtexterm_pal_sched
    import jtexterm_pkg::*;
#(
    parameter int PXL_MIN = 4
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [8:0] col_addr,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_rnw,
    input  logic       pal_cs,
    output logic [7:0] cpu_din,
    output logic       cpu_ok,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we,
    input  logic [7:0] ram_dout,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue
);

    pal_state_e  r_state;
    pal_state_e  w_next;
    logic [8:0]  r_col;
    logic        r_blank;
    logic [2:0]  r_vld_pipe;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_pix_ok;
    logic [14:0] w_rgb;
    logic        w_pend;
    logic        w_issue;
    logic        w_issue_rd;
    logic        w_issue_wr;
    logic        w_unused;

    // VLO is the E2 edge: the video low-byte address is already in the RAM,
    // so the bus is free for the CPU from here on.
    assign w_issue    = ~pxl_cen & w_pend & ((r_state == IDLE) | (r_state == VLO));
    assign w_issue_rd = w_issue & cpu_rnw;
    assign w_issue_wr = w_issue & ~cpu_rnw;
    assign w_rgb      = {r_hi[6:0], r_lo};
    assign w_unused   = r_hi[7] ^ (PXL_MIN < 4);

    always_comb begin
        w_next = r_state;
        if (pxl_cen) begin
            w_next = VHI;
        end else begin
            case (r_state)
                VHI:       w_next = VLO;
                VLO, IDLE: w_next = w_issue ? (cpu_rnw ? CPU_RD : CPU_DONE) : IDLE;
                CPU_RD:    w_next = CPU_DONE;
                CPU_DONE:  w_next = IDLE;
                default:   w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= 10'd0;
            ram_din  <= 8'd0;
            ram_we   <= 1'b0;
        end else begin
            ram_we <= w_issue_wr;
            if (pxl_cen)
                ram_addr <= {1'b1, col_addr};
            else if (r_state == VHI)
                ram_addr <= {1'b0, r_col};
            else if (w_issue)
                ram_addr <= cpu_addr;
            if (w_issue_wr)
                ram_din <= cpu_dout;
        end
    end

    // Capture phases follow pxl_cen, not the FSM, so CPU slots cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= 3'd0;
            r_col      <= 9'd0;
            r_blank    <= 1'b1;
            r_hi       <= 8'd0;
            r_lo       <= 8'd0;
            r_pix_ok   <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1:0], pxl_cen};
            if (r_vld_pipe[1])
                r_hi <= ram_dout;
            if (r_vld_pipe[2]) begin
                r_lo     <= ram_dout;
                r_pix_ok <= 1'b1;
            end
            if (pxl_cen) begin
                r_col   <= col_addr;
                r_blank <= ~LHBL | ~LVBL;
                if (r_pix_ok && !r_blank) begin
                    red   <= w_rgb[RED_HI:RED_LO];
                    green <= w_rgb[GRN_HI:GRN_LO];
                    blue  <= w_rgb[BLU_HI:BLU_LO];
                end else begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end
            end
        end
    end

    jtexterm_pal_cpuif u_cpuif (
        .rst        (rst),
        .clk        (clk),
        .i_pal_cs   (pal_cs),
        .i_issue_rd (w_issue_rd),
        .i_issue_wr (w_issue_wr),
        .i_ram_dout (ram_dout),
        .o_pend     (w_pend),
        .o_cpu_ok   (cpu_ok),
        .o_cpu_din  (cpu_din)
    );

endmodule

// File: tb/tb_jtexterm_pal_sched.sv
// Bench for jtexterm_pal_sched: synchronous RAM model, directed pixel/CPU
// scenarios, then random pixels with random CPU traffic against a palette model.
module tb_jtexterm_pal_sched;

    localparam int PXL_MIN = 4;
    localparam int LAT_MAX = PXL_MIN + 2;

    logic       rst = 1'b1;
    logic       clk = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b1;
    logic       LVBL = 1'b1;
    logic [8:0] col_addr = 9'd0;
    logic [9:0] cpu_addr = 10'd0;
    logic [7:0] cpu_dout = 8'd0;
    logic       cpu_rnw = 1'b1;
    logic       pal_cs = 1'b0;
    logic [7:0] cpu_din;
    logic       cpu_ok;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic [4:0] red, green, blue;

    logic [7:0] mem     [1024];
    logic [7:0] ref_mem [1024];
    logic       pre_we = 1'b0;
    logic [9:0] pre_a = 10'd0;
    logic [7:0] pre_d = 8'd0;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, ok_cnt = 0, we_cnt = 0, wr_done = 0, drop_cyc = -10, req_cyc = 0;
    bit req_out = 0, req_rnw = 0, auto_drop = 1;
    logic [7:0]  req_exp = 8'd0;
    logic [14:0] exp_prev = 15'd0;

    logic       we_ph   [PXL_MIN];
    logic       ok_ph   [PXL_MIN];
    logic [9:0] addr_ph [PXL_MIN];
    logic [7:0] din_ph  [PXL_MIN];
    logic [7:0] cdin_ph [PXL_MIN];

    jtexterm_pal_sched #(.PXL_MIN(PXL_MIN)) dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .col_addr(col_addr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rnw(cpu_rnw), .pal_cs(pal_cs), .cpu_din(cpu_din), .cpu_ok(cpu_ok),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_a]    <= pre_d;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ram_we) we_cnt++;
        if (req_out) begin
            chk("cpu_latency_bound", 32'(cyc - req_cyc <= LAT_MAX), 32'd1);
            if (cyc - req_cyc > LAT_MAX) begin
                req_out = 0; pal_cs = 1'b0; drop_cyc = cyc;
            end
        end
        if (cpu_ok) begin
            ok_cnt++;
            chk("cpu_ok_expected", 32'(req_out), 32'd1);
            if (req_out && req_rnw)  chk("cpu_din", cpu_din, req_exp);
            if (req_out && !req_rnw) wr_done++;
            req_out = 0;
            if (auto_drop) begin pal_cs = 1'b0; drop_cyc = cyc; end
        end
    endtask

    task automatic raise(input bit rnw, input logic [9:0] a, input logic [7:0] d);
        cpu_rnw = rnw; cpu_addr = a; cpu_dout = d; pal_cs = 1'b1;
        req_out = 1; req_rnw = rnw; req_cyc = cyc; req_exp = ref_mem[a];
        if (!rnw) ref_mem[a] = d;
    endtask

    // One pixel period; rph selects the phase at which a CPU request is raised (-1: none).
    task automatic pixel(input logic [8:0] col, input bit hb, input bit vb, input int rph,
                         input bit rnw, input logic [9:0] a, input logic [7:0] d);
        logic [14:0] exp_new;
        exp_new = (hb && vb) ? {ref_mem[{1'b1, col}][6:0], ref_mem[{1'b0, col}]} : 15'd0;
        for (int ph = 0; ph < PXL_MIN; ph++) begin
            if (ph == rph && !req_out && !pal_cs && cyc > drop_cyc) raise(rnw, a, d);
            pxl_cen = (ph == 0);
            if (ph == 0) begin col_addr = col; LHBL = hb; LVBL = vb; end
            tick();
            we_ph[ph] = ram_we; ok_ph[ph] = cpu_ok; addr_ph[ph] = ram_addr;
            din_ph[ph] = ram_din; cdin_ph[ph] = cpu_din;
            if (ph == 0) begin
                chk("colour", {red, green, blue}, exp_prev);
                exp_prev = exp_new;
                col_addr = 9'($urandom); LHBL = 1'($urandom); LVBL = 1'($urandom);
            end
        end
        pxl_cen = 1'b0;
    endtask

    initial begin
        int ok0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        ref_mem[10'h205] = 8'h7C;
        ref_mem[10'h005] = 8'h1F;

        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            pre_we = 1'b1; pre_a = 10'(i); pre_d = ref_mem[i];
            tick();
        end
        pre_we = 1'b0;
        chk("rst_colour", {red, green, blue}, 15'd0);
        chk("rst_cpu_ok", cpu_ok, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 10'd0);
        chk("rst_ram_din", ram_din, 8'd0);
        chk("rst_cpu_din", cpu_din, 8'd0);
        rst = 1'b0;
        tick();

        // Known pixel: 0x7C/0x1F -> 31,0,31
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        chk("px_red", red, 5'd31);
        chk("px_green", green, 5'd0);
        chk("px_blue", blue, 5'd31);

        // Blanked pixel gives zero colour one period later
        pixel(9'h005, 0, 1, -1, 0, 0, 0);
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        chk("blank_colour", {red, green, blue}, 15'd0);

        // Write requested on E0 lands at E2, cpu_ok at E3
        pixel(9'h005, 1, 1, 0, 0, 10'h10F, 8'h3A);
        chk("wr_we_e0", we_ph[0], 1'b0);
        chk("wr_we_e1", we_ph[1], 1'b0);
        chk("wr_we_e2", we_ph[2], 1'b1);
        chk("wr_addr_e2", addr_ph[2], 10'h10F);
        chk("wr_din_e2", din_ph[2], 8'h3A);
        chk("wr_we_e3", we_ph[3], 1'b0);
        chk("wr_ok_e3", ok_ph[3], 1'b1);
        chk("wr_addr_e1", addr_ph[1], {1'b0, 9'h005});

        // Read issued at E2 completes with the next E0; video keeps its slots
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        pixel(9'h007, 1, 1, 0, 1, 10'h10F, 8'h00);
        chk("rd_ok_early", ok_ph[3], 1'b0);
        pixel(9'h007, 1, 1, -1, 0, 0, 0);
        chk("rd_ok_e0", ok_ph[0], 1'b1);
        chk("rd_din_e0", cdin_ph[0], 8'h3A);
        chk("vid_addr_hi", addr_ph[0], {1'b1, 9'h007});
        chk("vid_addr_lo", addr_ph[1], {1'b0, 9'h007});

        // Held pal_cs yields a single access
        auto_drop = 0;
        ok0 = ok_cnt;
        raise(1, 10'h205, 8'h00);
        for (int k = 0; k < 5; k++) pixel(9'h005, 1, 1, -1, 0, 0, 0);
        chk("held_one_ok", 32'(ok_cnt - ok0), 32'd1);
        pal_cs = 1'b0; drop_cyc = cyc; auto_drop = 1;

        // Reset in the middle of a CPU read
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        raise(1, 10'h10F, 8'h00);
        pxl_cen = 1'b1; col_addr = 9'h005; LHBL = 1'b1; LVBL = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
        tick();
        chk("pre_rst_colour", {red, green, blue}, 15'h7C1F);
        #1 rst = 1'b1;
        #1;
        chk("arst_colour", {red, green, blue}, 15'd0);
        chk("arst_cpu_ok", cpu_ok, 1'b0);
        chk("arst_ram_we", ram_we, 1'b0);
        chk("arst_ram_addr", ram_addr, 10'd0);
        chk("arst_ram_din", ram_din, 8'd0);
        chk("arst_cpu_din", cpu_din, 8'd0);
        pal_cs = 1'b0; req_out = 0; drop_cyc = cyc; exp_prev = 15'd0;
        ok0 = ok_cnt;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b0;
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        chk("post_rst_zero", {red, green, blue}, 15'd0);
        chk("rst_no_ok", 32'(ok_cnt - ok0), 32'd0);
        pixel(9'h005, 1, 1, 0, 0, 10'h155, 8'hA5);
        chk("post_rst_we_e2", we_ph[2], 1'b1);
        chk("post_rst_addr_e2", addr_ph[2], 10'h155);
        chk("post_rst_ok_e3", ok_ph[3], 1'b1);

        // Random pixels with random CPU traffic
        for (int n = 0; n < 80; n++) begin
            int rph;
            rph = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PXL_MIN - 1)) : -1;
            pixel(9'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rph,
                  1'($urandom), 10'($urandom), 8'($urandom));
        end
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        pixel(9'h005, 1, 1, -1, 0, 0, 0);
        chk("no_outstanding", 32'(req_out), 32'd0);
        chk("we_cycles_vs_writes", 32'(we_cnt), 32'(wr_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
